booth_mult_seq: RTL
===================

Name: booth_mult_seq

Overview:
Parametrised sequential radix-2 Booth multiplier. It is the successor to the fixed 4-bit Booth unit. It adds generic operand width, a signed/unsigned mode select and a start/busy/done handshake, so operations no longer have to be launched through reset. It is intended as a shared multiply resource for datapath blocks that tolerate multi-cycle latency.

Parameters:
WIDTH, 4, operand width in bits (min 2); result is 2*WIDTH bits.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only while idle
signed_mode  input  1  1 = operands two's complement, 0 = unsigned; sampled with start
m  input  WIDTH  multiplicand; sampled with start
q  input  WIDTH  multiplier; sampled with start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse: result valid and newly updated
result  output  2*WIDTH  product of last completed operation; held until next completion

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE; busy=0, done=0, result=0; internal accumulator, shift register and counter are cleared. Reset wins over every other event, including start and an in-flight operation. An aborted operation never produces done.
- Internal width: E = WIDTH+1. Operands are extended to E bits: sign-extended if signed_mode=1, zero-extended if 0. This one datapath then covers both modes.
- State machine, IDLE -> RUN -> IDLE:
  - IDLE, start=1: latch M=ext(m), Q=ext(q), A=0 (E bits), Q_1=0, cnt=E; busy<=1; go to RUN.
  - IDLE, start=0: hold. done<=0.
  - RUN, each cycle, one Booth step on pair {Q[0],Q_1}:
    - 10: A=A-M
    - 01: A=A+M
    - 00/11: no change
    - Then arithmetic right shift of {A,Q,Q_1} by 1 (sign of A replicated). cnt decrements.
  - RUN, step with cnt==1 (final): result<=low 2*WIDTH bits of the shifted {A,Q}; done<=1; busy<=0; go to IDLE.
- A and M arithmetic is E bits, wrapping. Truncating the 2E-bit product to 2*WIDTH bits is exact in both modes.
- Latency: start accepted at edge t0. done is high during the cycle after edge t0+E, i.e. WIDTH+1 cycles after acceptance. busy is high for exactly E cycles.
- start while busy=1 is ignored; no queuing.
- Back-to-back: start=1 during the done cycle (state is IDLE) is accepted. done then deasserts next cycle and busy reasserts.
- m, q and signed_mode may change freely after acceptance; the operation uses the latched values.
- done lasts exactly one cycle. result is stable between completions and is never modified during RUN.
- Throughput: one result per E+1 cycles when start is held high continuously. Acceptance occurs on every IDLE cycle with start=1.

Test Plan:
1. WIDTH=4, signed_mode=1, m=3, q=2, start one cycle -> busy high 5 cycles; done pulse exactly 5 cycles after acceptance; result=8'h06.
2. signed, m=-3 (4'hD), q=2 -> result=8'hFA (-6). Then m=-4 (4'hC), q=-3 (4'hD) -> 8'h0C (12). Then m=0, q=5 -> 8'h00.
3. Extremes: signed m=-8, q=-8 -> 8'h40 (64). Unsigned m=15, q=15 -> 8'hE1 (225). Unsigned m=8, q=2 -> 8'h10. Check that the same bits in signed mode give 8'hF0.
4. Handshake:
   - start held high continuously with changing operands -> results every 6 cycles, each matching operands latched at acceptance.
   - start pulses during busy -> ignored; result unchanged; no extra done.
5. Reset mid-operation: rst=1 on 3rd RUN cycle -> next cycle busy=0, done=0, result=0. No done follows. A new start after reset completes correctly.
6. Parameter sweep WIDTH=8 and WIDTH=16, randomized signed/unsigned operands (≥1000 each) against a reference model. Include min/max values and checks that latency equals WIDTH+1.

Source files
------------

// File: rtl/booth_mult_seq.sv
// rtl/booth_mult_seq.sv - sequential radix-2 Booth multiplier with start/busy/done handshake
module booth_mult_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     m,
    input  logic [WIDTH-1:0]     q,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    // One extra bit lets a single signed datapath handle zero-extended unsigned operands.
    localparam int E  = WIDTH + 1;
    localparam int CW = $clog2(E + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_INIT = CW'(E);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state, state_next;

    logic [E-1:0]  a_reg, m_reg, q_reg;
    logic          q_1;
    logic [CW-1:0] cnt;

    logic [E-1:0]  m_ext, q_ext;
    logic [E-1:0]  a_sum, a_shr, q_shr;
    logic          load, step, last;

    always_comb begin
        m_ext = signed_mode ? {m[WIDTH-1], m} : {1'b0, m};
        q_ext = signed_mode ? {q[WIDTH-1], q} : {1'b0, q};
    end

    always_comb begin
        a_sum = a_reg;
        case ({q_reg[0], q_1})
            2'b10:   a_sum = a_reg - m_reg;
            2'b01:   a_sum = a_reg + m_reg;
            default: a_sum = a_reg;
        endcase
        a_shr = {a_sum[E-1], a_sum[E-1:1]};
        q_shr = {a_sum[0], q_reg[E-1:1]};
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == CNT_ONE) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg  <= '0;
            m_reg  <= '0;
            q_reg  <= '0;
            q_1    <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            if (load) begin
                a_reg <= '0;
                m_reg <= m_ext;
                q_reg <= q_ext;
                q_1   <= 1'b0;
                cnt   <= CNT_INIT;
                busy  <= 1'b1;
            end else if (step) begin
                a_reg <= a_shr;
                q_reg <= q_shr;
                q_1   <= q_reg[0];
                cnt   <= cnt - CNT_ONE;
                // 2E-bit product truncated to 2*WIDTH bits is exact in both modes.
                if (last) begin
                    result <= {a_shr[WIDTH-2:0], q_shr};
                    done   <= 1'b1;
                    busy   <= 1'b0;
                end
            end
        end
    end

endmodule
